fetch_stage1: RTL and testbench
===============================

FETCH_STAGE1 -- requirements
Module: fetch_stage1

Interface
REQ-001 SHALL have parameter BRANCH_SHADOW, default 2, number of cycles block_fetch is held after a control-transfer instruction (range 1..7).
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port inbound_instruction  input  32  instruction word from stage 0.
REQ-005 SHALL have port outbound_instruction  output  32  instruction word passed to stage 2 (registered).
REQ-006 SHALL have port reg_dest_index  output  4  bits [26:23] of outbound_instruction.
REQ-007 SHALL have port reg_a_index  output  4  bits [22:19] of outbound_instruction.
REQ-008 SHALL have port reg_b_index  output  4  bits [18:15] of outbound_instruction.
REQ-009 SHALL have port writes_reg  output  1  outbound_instruction writes reg_dest_index.
REQ-010 SHALL have port block_fetch  output  1  registered; stage 0 and PC hold/insert NOP while high.

Function
REQ-011 SHALL decode opcode from inbound_instruction[31:27] using the shared opcode type.
REQ-012 SHALL register all outputs; latency inbound to outbound one cycle.
REQ-013 SHALL implement states RUNNING, SHADOW, INTERLOCK.
REQ-014 RUNNING: non-control instruction passes unchanged, block_fetch low.
REQ-015 RUNNING: control-transfer opcode (JUMP, BRANCH, CALL, RETURN) passes unchanged, block_fetch high next cycle, shadow counter loaded with BRANCH_SHADOW-1, go SHADOW.
REQ-016 SHADOW: block_fetch high; inbound words still pass; counter decrements each cycle; at counter 0 return to RUNNING with block_fetch low the following cycle (exactly BRANCH_SHADOW high cycles).
REQ-017 SHADOW: a control-transfer opcode arriving in shadow SHALL be passed but SHALL NOT reload the counter.
REQ-018 writes_reg SHALL be high for LOAD, ALU, CALL, and MOVE-immediate classes, low otherwise, including NOP.
REQ-019 HALT SHALL pass as an ordinary non-control instruction; subsequent NOPs from stage 0 pass unchanged.
REQ-020 Shadow counter SHALL be 3 bits and never wrap below 0.

Reset
REQ-021 On reset: outbound_instruction = {OPCODE_NOP, 27'h0}, index outputs 0, writes_reg 0, block_fetch 0, counter 0, holding register NOP, state RUNNING.
REQ-022 Reset asserted in SHADOW or INTERLOCK SHALL abandon the state immediately; first post-reset cycle behaves as RUNNING.

Configuration
REQ-023 Macro LOAD_USE_INTERLOCK_EN SHALL enable load-use interlock.
REQ-024 With macro: if outbound_instruction is LOAD and inbound instruction reads reg_dest_index as reg A or reg B, SHALL capture inbound into holding register, output NOP, raise block_fetch, go INTERLOCK.
REQ-025 With macro: INTERLOCK lasts one cycle; holding instruction then output, inbound discarded, block_fetch low, state RUNNING (or SHADOW if held word is control-transfer).
REQ-026 With macro: load-use check SHALL NOT apply in SHADOW; load-use takes priority over control-transfer detection in RUNNING.
REQ-027 Without macro: INTERLOCK state and holding register SHALL be absent; loads pass like any instruction.

Structure
REQ-028 Opcode type, OPCODE_* values, instruction field bit positions and opcode class functions (is_control, writes_reg, reads_a, reads_b) SHALL live in shared opcodes.vh.
REQ-029 Register index width and count SHALL live in shared registers.vh.
REQ-030 Sub-module shadow_counter (load, decrement, zero flag) is natural; all other logic lives in fetch_stage1.

Verification
REQ-031 Reset then stream ADD r1,r2,r3 -> outbound equals input one cycle later, block_fetch 0, writes_reg 1, indices 1/2/3.
REQ-032 JUMP with BRANCH_SHADOW=2 -> block_fetch high exactly 2 cycles starting the cycle JUMP appears on outbound.
REQ-033 BRANCH then BRANCH in shadow -> block_fetch still exactly 2 cycles, no extension.
REQ-034 With LOAD_USE_INTERLOCK_EN: LOAD r4 then ADD r5,r4,r6 -> outbound LOAD, NOP, ADD; block_fetch high one cycle; without macro -> LOAD, ADD, no block.
REQ-035 Reset pulse during shadow cycle 1 -> outbound NOP, block_fetch 0 immediately; next ADD passes normally.
REQ-036 HALT followed by NOPs -> HALT appears once on outbound, then NOPs, block_fetch 0.

Source files
------------

// File: rtl/fetch_stage1_pkg.sv
// rtl/fetch_stage1_pkg.sv - shared opcode, instruction-field and register-file definitions
// Interlock state exists only when LOAD_USE_INTERLOCK_EN is defined.
package fetch_stage1_pkg;

  localparam int REG_COUNT = 16;
  localparam int REG_IDX_W = $clog2(REG_COUNT);

  localparam int INSN_W     = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int DEST_MSB   = 26;
  localparam int DEST_LSB   = 23;
  localparam int REG_A_MSB  = 22;
  localparam int REG_A_LSB  = 19;
  localparam int REG_B_MSB  = 18;
  localparam int REG_B_LSB  = 15;

  typedef enum logic [4:0] {
    OPCODE_NOP    = 5'd0,
    OPCODE_ALU    = 5'd1,
    OPCODE_LOAD   = 5'd2,
    OPCODE_STORE  = 5'd3,
    OPCODE_MOVI   = 5'd4,
    OPCODE_JUMP   = 5'd5,
    OPCODE_BRANCH = 5'd6,
    OPCODE_CALL   = 5'd7,
    OPCODE_RETURN = 5'd8,
    OPCODE_HALT   = 5'd9
  } opcode_t;

  localparam logic [INSN_W-1:0] NOP_WORD = {OPCODE_NOP, 27'h0};

`ifdef LOAD_USE_INTERLOCK_EN
  typedef enum logic [1:0] {ST_RUNNING, ST_SHADOW, ST_INTERLOCK} state_t;
`else
  typedef enum logic [1:0] {ST_RUNNING, ST_SHADOW} state_t;
`endif

  function automatic opcode_t get_opcode(input logic [INSN_W-1:0] word);
    return opcode_t'(word[OPCODE_MSB:OPCODE_LSB]);
  endfunction

  function automatic logic [REG_IDX_W-1:0] get_dest(input logic [INSN_W-1:0] word);
    return word[DEST_MSB:DEST_LSB];
  endfunction

  function automatic logic [REG_IDX_W-1:0] get_reg_a(input logic [INSN_W-1:0] word);
    return word[REG_A_MSB:REG_A_LSB];
  endfunction

  function automatic logic [REG_IDX_W-1:0] get_reg_b(input logic [INSN_W-1:0] word);
    return word[REG_B_MSB:REG_B_LSB];
  endfunction

  function automatic logic is_control(input opcode_t op);
    return op inside {OPCODE_JUMP, OPCODE_BRANCH, OPCODE_CALL, OPCODE_RETURN};
  endfunction

  function automatic logic writes_reg(input opcode_t op);
    return op inside {OPCODE_LOAD, OPCODE_ALU, OPCODE_CALL, OPCODE_MOVI};
  endfunction

  // LOAD and STORE use reg A as the address base; BRANCH compares A against B.
  function automatic logic reads_a(input opcode_t op);
    return op inside {OPCODE_ALU, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH};
  endfunction

  function automatic logic reads_b(input opcode_t op);
    return op inside {OPCODE_ALU, OPCODE_STORE, OPCODE_BRANCH};
  endfunction

endpackage

// File: rtl/fetch_stage1_shadow_counter.sv
// rtl/fetch_stage1_shadow_counter.sv - 3-bit branch-shadow down-counter that saturates at zero
module shadow_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_value,
  input  logic       decrement,
  output logic       zero
);

  logic [2:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= 3'd0;
    end else if (load) begin
      r_count <= load_value;
    end else if (decrement && (r_count != 3'd0)) begin
      r_count <= r_count - 3'd1;
    end
  end

  assign zero = (r_count == 3'd0);

endmodule

// File: rtl/fetch_stage1.sv
// rtl/fetch_stage1.sv - fetch stage 1: decode, branch-shadow fetch blocking, optional load-use interlock
// Optional feature: define LOAD_USE_INTERLOCK_EN to enable the load-use interlock.
module fetch_stage1
  import fetch_stage1_pkg::*;
#(
  parameter int BRANCH_SHADOW = 2
) (
  input  logic        reset,
  input  logic        clock,
  input  logic [31:0] inbound_instruction,
  output logic [31:0] outbound_instruction,
  output logic [3:0]  reg_dest_index,
  output logic [3:0]  reg_a_index,
  output logic [3:0]  reg_b_index,
  output logic        writes_reg,
  output logic        block_fetch
);

  localparam logic [2:0] SHADOW_INIT = 3'(BRANCH_SHADOW - 1);

  state_t      r_state;
  logic [31:0] r_outbound;
  logic        r_writes_reg;
  logic        r_block_fetch;

  opcode_t     w_in_op;
  logic        w_in_control;
  logic        w_cnt_load;
  logic        w_cnt_dec;
  logic        w_cnt_zero;

  assign w_in_op      = get_opcode(inbound_instruction);
  assign w_in_control = is_control(w_in_op);

`ifdef LOAD_USE_INTERLOCK_EN
  logic [31:0] r_hold;
  opcode_t     w_hold_op;
  logic        w_load_use;

  assign w_hold_op = get_opcode(r_hold);

  // Only a LOAD already on the outbound side can hazard the word arriving now.
  assign w_load_use = (get_opcode(r_outbound) == OPCODE_LOAD) &&
                      ((reads_a(w_in_op) && (get_reg_a(inbound_instruction) == get_dest(r_outbound))) ||
                       (reads_b(w_in_op) && (get_reg_b(inbound_instruction) == get_dest(r_outbound))));
`endif

  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      ST_RUNNING: begin
`ifdef LOAD_USE_INTERLOCK_EN
        w_cnt_load = w_in_control && !w_load_use;
`else
        w_cnt_load = w_in_control;
`endif
      end
      ST_SHADOW:    w_cnt_dec  = !w_cnt_zero;
`ifdef LOAD_USE_INTERLOCK_EN
      ST_INTERLOCK: w_cnt_load = is_control(w_hold_op);
`endif
      default: begin
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
      end
    endcase
  end

  shadow_counter u_shadow_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (w_cnt_load),
    .load_value (SHADOW_INIT),
    .decrement  (w_cnt_dec),
    .zero       (w_cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RUNNING;
      r_outbound    <= NOP_WORD;
      r_writes_reg  <= 1'b0;
      r_block_fetch <= 1'b0;
`ifdef LOAD_USE_INTERLOCK_EN
      r_hold        <= NOP_WORD;
`endif
    end else begin
      case (r_state)
        ST_RUNNING: begin
`ifdef LOAD_USE_INTERLOCK_EN
          if (w_load_use) begin
            r_hold        <= inbound_instruction;
            r_outbound    <= NOP_WORD;
            r_writes_reg  <= 1'b0;
            r_block_fetch <= 1'b1;
            r_state       <= ST_INTERLOCK;
          end else
`endif
          begin
            r_outbound    <= inbound_instruction;
            r_writes_reg  <= fetch_stage1_pkg::writes_reg(w_in_op);
            r_block_fetch <= w_in_control;
            r_state       <= w_in_control ? ST_SHADOW : ST_RUNNING;
          end
        end

        // Control transfers arriving here pass through but never reload the counter.
        ST_SHADOW: begin
          r_outbound    <= inbound_instruction;
          r_writes_reg  <= fetch_stage1_pkg::writes_reg(w_in_op);
          r_block_fetch <= !w_cnt_zero;
          r_state       <= w_cnt_zero ? ST_RUNNING : ST_SHADOW;
        end

`ifdef LOAD_USE_INTERLOCK_EN
        // Stage 0 was held, so the inbound word is a repeat of r_hold and is dropped.
        ST_INTERLOCK: begin
          r_outbound    <= r_hold;
          r_writes_reg  <= fetch_stage1_pkg::writes_reg(w_hold_op);
          r_block_fetch <= is_control(w_hold_op);
          r_state       <= is_control(w_hold_op) ? ST_SHADOW : ST_RUNNING;
        end
`endif

        default: begin
          r_outbound    <= NOP_WORD;
          r_writes_reg  <= 1'b0;
          r_block_fetch <= 1'b0;
          r_state       <= ST_RUNNING;
        end
      endcase
    end
  end

  assign outbound_instruction = r_outbound;
  assign reg_dest_index       = get_dest(r_outbound);
  assign reg_a_index          = get_reg_a(r_outbound);
  assign reg_b_index          = get_reg_b(r_outbound);
  assign writes_reg           = r_writes_reg;
  assign block_fetch          = r_block_fetch;

endmodule

// File: tb/tb_fetch_stage1.sv
// tb/tb_fetch_stage1.sv - directed self-checking bench for fetch_stage1 (BRANCH_SHADOW=2)
module tb_fetch_stage1;

  logic        clock;
  logic        reset;
  logic [31:0] inbound_instruction;
  logic [31:0] outbound_instruction;
  logic [3:0]  reg_dest_index;
  logic [3:0]  reg_a_index;
  logic [3:0]  reg_b_index;
  logic        writes_reg;
  logic        block_fetch;

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage1 #(.BRANCH_SHADOW(2)) dut (
    .reset                (reset),
    .clock                (clock),
    .inbound_instruction  (inbound_instruction),
    .outbound_instruction (outbound_instruction),
    .reg_dest_index       (reg_dest_index),
    .reg_a_index          (reg_a_index),
    .reg_b_index          (reg_b_index),
    .writes_reg           (writes_reg),
    .block_fetch          (block_fetch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Opcode encodings: NOP=0 ALU=1 LOAD=2 JUMP=5 BRANCH=6 HALT=9
  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] d,
                                     input logic [3:0] a, input logic [3:0] b);
    return {op, d, a, b, 15'h0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] nop_w, add_w, jump_w, br_w, load_w, add2_w, halt_w;

  initial begin
    nop_w  = 32'h0000_0000;
    add_w  = mk(5'd1, 4'd1, 4'd2, 4'd3);
    jump_w = mk(5'd5, 4'd0, 4'd0, 4'd0);
    br_w   = mk(5'd6, 4'd0, 4'd1, 4'd2);
    load_w = mk(5'd2, 4'd4, 4'd1, 4'd0);
    add2_w = mk(5'd1, 4'd5, 4'd4, 4'd6);
    halt_w = mk(5'd9, 4'd0, 4'd0, 4'd0);

    reset = 1'b1;
    inbound_instruction = add_w;
    step();
    step();
    check("reset_out",   outbound_instruction, nop_w);
    check("reset_bf",    32'(block_fetch), 32'd0);
    check("reset_wr",    32'(writes_reg), 32'd0);
    check("reset_idx",   {20'h0, reg_dest_index, reg_a_index, reg_b_index}, 32'h0);

    @(negedge clock);
    reset = 1'b0;

    inbound_instruction = add_w;
    step();
    check("add_out",  outbound_instruction, add_w);
    check("add_bf",   32'(block_fetch), 32'd0);
    check("add_wr",   32'(writes_reg), 32'd1);
    check("add_idx",  {20'h0, reg_dest_index, reg_a_index, reg_b_index}, 32'h123);

    inbound_instruction = jump_w;
    step();
    check("jump_out", outbound_instruction, jump_w);
    check("jump_bf0", 32'(block_fetch), 32'd1);
    check("jump_wr",  32'(writes_reg), 32'd0);
    inbound_instruction = nop_w;
    step();
    check("jump_bf1", 32'(block_fetch), 32'd1);
    step();
    check("jump_bf2", 32'(block_fetch), 32'd0);
    step();
    check("jump_bf3", 32'(block_fetch), 32'd0);

    inbound_instruction = br_w;
    step();
    check("br_out0",  outbound_instruction, br_w);
    check("br_bf0",   32'(block_fetch), 32'd1);
    step();
    check("br_out1",  outbound_instruction, br_w);
    check("br_bf1",   32'(block_fetch), 32'd1);
    inbound_instruction = nop_w;
    step();
    check("br_bf2",   32'(block_fetch), 32'd0);
    step();
    check("br_bf3",   32'(block_fetch), 32'd0);

    inbound_instruction = load_w;
    step();
    check("ld_out",   outbound_instruction, load_w);
    check("ld_wr",    32'(writes_reg), 32'd1);
    check("ld_bf",    32'(block_fetch), 32'd0);
    inbound_instruction = add2_w;
    step();
`ifdef LOAD_USE_INTERLOCK_EN
    check("lu_nop",   outbound_instruction, nop_w);
    check("lu_bf",    32'(block_fetch), 32'd1);
    check("lu_wr",    32'(writes_reg), 32'd0);
    step();
    check("lu_add",   outbound_instruction, add2_w);
    check("lu_bf2",   32'(block_fetch), 32'd0);
    check("lu_wr2",   32'(writes_reg), 32'd1);
`else
    check("lu_add",   outbound_instruction, add2_w);
    check("lu_bf",    32'(block_fetch), 32'd0);
    check("lu_wr",    32'(writes_reg), 32'd1);
`endif
    inbound_instruction = nop_w;
    step();
    check("lu_tail",  outbound_instruction, nop_w);

    inbound_instruction = jump_w;
    step();
    check("rs_bf_pre", 32'(block_fetch), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rs_out",   outbound_instruction, nop_w);
    check("rs_bf",    32'(block_fetch), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    inbound_instruction = add_w;
    step();
    check("rs_add",   outbound_instruction, add_w);
    check("rs_add_bf", 32'(block_fetch), 32'd0);
    inbound_instruction = nop_w;
    step();
    check("rs_add_bf2", 32'(block_fetch), 32'd0);

    inbound_instruction = halt_w;
    step();
    check("halt_out", outbound_instruction, halt_w);
    check("halt_bf",  32'(block_fetch), 32'd0);
    check("halt_wr",  32'(writes_reg), 32'd0);
    inbound_instruction = nop_w;
    step();
    check("halt_nop1", outbound_instruction, nop_w);
    step();
    check("halt_nop2", outbound_instruction, nop_w);
    check("halt_bf2",  32'(block_fetch), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
